ast_pack: RTL and testbench
===========================

Name: ast_pack

Overview:
- Avalon-ST source-side packer. Takes a byte-serial packet stream (one byte per beat, with sop/eop) and assembles AST_SOURCE_SYMBOLS-wide Avalon-ST beats with startofpacket, endofpacket and empty.
- It is the transmit counterpart of the window-extraction sink path. Upstream byte producers (pattern generators, test-vector players) use it to drive the bloom-filter Avalon-ST input.
- Double-buffered: output register plus accumulator. Full throughput: one input byte per cycle.

Parameters:
- BYTE_W, 8, bits per symbol.
- AST_SOURCE_SYMBOLS, 8, symbols per output beat; must be ≥1.
- AST_SOURCE_ORDER, 1. 1 = first byte of a beat goes in symbol [AST_SOURCE_SYMBOLS-1] (big-endian Avalon). 0 = first byte goes in symbol [0].
- AST_SOURCE_EMPTY_W, (AST_SOURCE_SYMBOLS==1) ? 1 : $clog2(AST_SOURCE_SYMBOLS), width of the empty field.
- DROP_CNT_W, 16, width of the dropped-byte counter.

Ports:
- clk_i  in  1  clock.
- srst_i  in  1  synchronous reset, active-high.
- byte_data_i  in  BYTE_W  input byte.
- byte_valid_i  in  1  input byte valid.
- byte_ready_o  out  1  input ready; a transfer occurs when valid && ready.
- byte_sop_i  in  1  first byte of a packet.
- byte_eop_i  in  1  last byte of a packet.
- ast_source_data_o  out  AST_SOURCE_SYMBOLS*BYTE_W  output beat, packed [SYMBOLS-1:0][BYTE_W-1:0].
- ast_source_valid_o  out  1  output beat valid.
- ast_source_ready_i  in  1  downstream ready; ready latency 0.
- ast_source_empty_o  out  AST_SOURCE_EMPTY_W  number of unused symbols in the beat; nonzero only on eop beats.
- ast_source_startofpacket_o  out  1  first beat of a packet.
- ast_source_endofpacket_o  out  1  last beat of a packet.
- drop_cnt_o  out  DROP_CNT_W  saturating count of bytes discarded outside a packet.

Behaviour:

State:
- Accumulator acc[SYMBOLS] with fill count acc_cnt (0..SYMBOLS).
- Flags: acc_sop, acc_done, in_pkt.
- Output register: data/empty/sop/eop plus out_valid.

Reset values:
- ast_source_valid_o = 0; data, empty, sop and eop outputs = 0.
- drop_cnt_o = 0, acc_cnt = 0, acc_done = 0, in_pkt = 0.
- byte_ready_o = 1 in the first cycle after reset is released.

Handshake rules:
- out_free = !out_valid || ast_source_ready_i.
- byte_ready_o = !acc_done. It is combinational from state only, never from byte_valid_i.
- Output data, empty, sop and eop are held stable while out_valid && !ast_source_ready_i.

Packet framing on an accepted byte:
- If byte_sop_i=1: set in_pkt=1 and acc_sop=1. The byte is the first in the packet.
- Else if in_pkt=0: discard the byte and increment drop_cnt_o, saturating at all-ones.
- Else: append the byte.
- A sop while in_pkt=1 is treated as an ordinary byte: it is appended, no new packet starts, and acc_sop is not set.
- A byte with both sop and eop forms a 1-byte packet.

Byte placement:
- Byte k of a beat (k = 0..SYMBOLS-1) goes to symbol SYMBOLS-1-k when ORDER=1, and to symbol k when ORDER=0.
- Unfilled symbols are driven to 0.

Beat completion:
- A beat completes on the accepted byte that makes acc_cnt reach SYMBOLS, or on an accepted byte with eop.
- On completion, if out_free: the assembled beat (acc plus the incoming byte) loads the output register next edge, out_valid=1. Latency is 1 cycle from the completing byte to valid. acc_cnt is cleared.
- On completion, if !out_free: the beat is written into acc and acc_done=1, so byte_ready_o=0.
- While acc_done: when out_free, acc moves to the output register next edge, acc_done clears, and byte_ready_o rises the following cycle.
- Output fields on load:
  - sop = acc_sop; acc_sop is then cleared.
  - eop = eop of the completing byte; eop also clears in_pkt.
  - empty = SYMBOLS - bytes_in_beat on eop beats, otherwise 0.
- Simultaneous pop and load: when out_valid && ast_source_ready_i and a beat completes in the same cycle, the register reloads with no bubble. Sustained rate is one beat per SYMBOLS cycles.
- When a pop occurs with nothing to load, out_valid clears.

Other rules:
- SYMBOLS=1: every accepted in-packet byte completes a beat, and empty is always 0.
- Reset mid-operation: all partial accumulator content and any pending output beat are discarded; there is no flush beat.
- Widths: acc_cnt is $clog2(SYMBOLS+1) bits. Empty is computed at that width and truncated to AST_SOURCE_EMPTY_W.

Test Plan:
1. SYMBOLS=8, ORDER=1, source_ready=1. Send an 8-byte packet 01..08 (sop on 01, eop on 08). Required: exactly one beat, one cycle after 08 is accepted, with data=0x0102030405060708, sop=1, eop=1, empty=0.
2. Send an 11-byte packet 01..0B.
   - Beat 1: sop=1, eop=0, empty=0, data=0x0102030405060708.
   - Beat 2: sop=0, eop=1, empty=5, data=0x090A0B0000000000.
   - ORDER=0 rerun: beat 2 data=0x00000000000B0A09.
3. Backpressure: hold source_ready=0 while streaming a 24-byte packet. Required:
   - byte_ready_o drops after 16 bytes are accepted.
   - Releasing ready yields beats 1, 2, 3 in order with no loss and no duplication.
   - Valid is never dropped while stalled.
4. Single byte with sop=eop=1, data 0xAA. Required: data=0xAA00000000000000, sop=1, eop=1, empty=7. Then a back-to-back second packet starts with sop=1.
5. Three bytes without sop outside a packet, then a valid 8-byte packet. Required: drop_cnt_o=3, no beat for the dropped bytes, and a correct packet beat afterwards. Also preload drop_cnt to max-1, drop 2 bytes, and check it saturates at 0xFFFF.
6. Assert srst_i for 1 cycle after 5 bytes of a packet. Required:
   - valid=0 the next cycle, drop_cnt_o=0.
   - Subsequent bytes without sop are dropped.
   - The next sop packet contains no stale bytes.

Source files
------------

// File: rtl/ast_pack.sv
// Avalon-ST source packer: byte-serial packets in, SYMBOLS-wide beats out.
// Accumulator plus output register; one input byte per cycle.
module ast_pack #(
  parameter int BYTE_W             = 8,
  parameter int AST_SOURCE_SYMBOLS = 8,
  parameter int AST_SOURCE_ORDER   = 1,
  parameter int AST_SOURCE_EMPTY_W =
    (AST_SOURCE_SYMBOLS == 1) ? 1 : $clog2(AST_SOURCE_SYMBOLS),
  parameter int DROP_CNT_W         = 16
) (
  input  logic                                 clk_i,
  input  logic                                 srst_i,
  input  logic [BYTE_W-1:0]                    byte_data_i,
  input  logic                                 byte_valid_i,
  output logic                                 byte_ready_o,
  input  logic                                 byte_sop_i,
  input  logic                                 byte_eop_i,
  output logic [AST_SOURCE_SYMBOLS*BYTE_W-1:0] ast_source_data_o,
  output logic                                 ast_source_valid_o,
  input  logic                                 ast_source_ready_i,
  output logic [AST_SOURCE_EMPTY_W-1:0]        ast_source_empty_o,
  output logic                                 ast_source_startofpacket_o,
  output logic                                 ast_source_endofpacket_o,
  output logic [DROP_CNT_W-1:0]                drop_cnt_o
);

  localparam int S     = AST_SOURCE_SYMBOLS;
  localparam int CNT_W = $clog2(S + 1);
  localparam int EW    = AST_SOURCE_EMPTY_W;

  typedef logic [S-1:0][BYTE_W-1:0] beat_t;

  beat_t            acc;
  beat_t            out_data;
  logic [CNT_W-1:0] acc_cnt;
  logic             acc_sop;
  logic             acc_eop;
  logic             acc_done;
  logic [EW-1:0]    acc_empty;
  logic             in_pkt;
  logic             out_valid;
  logic             out_sop;
  logic             out_eop;
  logic [EW-1:0]    out_empty;
  logic [DROP_CNT_W-1:0] drop_cnt;

  logic             out_free;
  logic             accept;
  logic             start;
  logic             append;
  logic             drop;
  logic             complete;
  logic             sop_now;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] pos;
  logic [CNT_W-1:0] rem;
  logic [EW-1:0]    empty_next;
  beat_t            beat_next;

  always_comb begin
    out_free   = !out_valid || ast_source_ready_i;
    accept     = byte_valid_i && !acc_done;
    start      = accept && byte_sop_i && !in_pkt;
    append     = accept && (in_pkt || byte_sop_i);
    drop       = accept && !in_pkt && !byte_sop_i;
    cnt_next   = acc_cnt + CNT_W'(1);
    complete   = append && (cnt_next == CNT_W'(S) || byte_eop_i);
    sop_now    = acc_sop || start;
    pos        = (AST_SOURCE_ORDER != 0) ?
                 CNT_W'(S - 1) - acc_cnt : acc_cnt;
    beat_next  = acc;
    for (int k = 0; k < S; k++) begin
      if (CNT_W'(k) == pos) beat_next[k] = byte_data_i;
    end
    rem        = CNT_W'(S) - cnt_next;
    empty_next = byte_eop_i ? rem[EW-1:0] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      acc       <= '0;
      acc_cnt   <= '0;
      acc_sop   <= 1'b0;
      acc_eop   <= 1'b0;
      acc_done  <= 1'b0;
      acc_empty <= '0;
      in_pkt    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_empty <= '0;
      drop_cnt  <= '0;
    end else begin
      if (out_valid && ast_source_ready_i) out_valid <= 1'b0;
      // A parked beat always drains before new bytes are taken.
      if (acc_done) begin
        if (out_free) begin
          out_data  <= acc;
          out_sop   <= acc_sop;
          out_eop   <= acc_eop;
          out_empty <= acc_empty;
          out_valid <= 1'b1;
          acc       <= '0;
          acc_sop   <= 1'b0;
          acc_done  <= 1'b0;
        end
      end else if (complete) begin
        acc_cnt <= '0;
        in_pkt  <= !byte_eop_i;
        if (out_free) begin
          out_data  <= beat_next;
          out_sop   <= sop_now;
          out_eop   <= byte_eop_i;
          out_empty <= empty_next;
          out_valid <= 1'b1;
          acc       <= '0;
          acc_sop   <= 1'b0;
        end else begin
          acc       <= beat_next;
          acc_sop   <= sop_now;
          acc_eop   <= byte_eop_i;
          acc_empty <= empty_next;
          acc_done  <= 1'b1;
        end
      end else if (append) begin
        acc     <= beat_next;
        acc_cnt <= cnt_next;
        acc_sop <= sop_now;
        in_pkt  <= 1'b1;
      end
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end

  assign byte_ready_o               = !acc_done;
  assign ast_source_data_o          = out_data;
  assign ast_source_valid_o         = out_valid;
  assign ast_source_empty_o         = out_empty;
  assign ast_source_startofpacket_o = out_sop;
  assign ast_source_endofpacket_o   = out_eop;
  assign drop_cnt_o                 = drop_cnt;

endmodule

// File: tb/tb_ast_pack.sv
// Bench for ast_pack: directed scenarios plus random packets
// checked against a queue-based packetizing model.
module tb_ast_pack;

  localparam int S = 8;

  typedef struct packed {
    logic [63:0] d1;
    logic [63:0] d0;
    logic        sop;
    logic        eop;
    logic [2:0]  emp;
  } beat_t;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic [7:0]  byte_data = '0;
  logic        byte_valid = 1'b0;
  logic        byte_sop = 1'b0;
  logic        byte_eop = 1'b0;
  logic        byte_ready, byte_ready0;
  logic [63:0] data, data0;
  logic        valid, valid0;
  logic        src_ready = 1'b1;
  logic [2:0]  empty, empty0;
  logic        sop, sop0, eop, eop0;
  logic [15:0] drop;
  logic [3:0]  drop0;

  int checks = 0;
  int failures = 0;
  int stall_bad = 0;
  int twin_bad = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] held_d;
  logic [4:0]  held_f;

  bit         m_in_pkt;
  bit         m_sop;
  int         m_drops;
  logic [7:0] m_chunk[$];
  beat_t      exp_q[$];
  beat_t      obs_q[$];

  always #5 clk = ~clk;

  ast_pack u_dut (
    .clk_i(clk), .srst_i(srst),
    .byte_data_i(byte_data), .byte_valid_i(byte_valid),
    .byte_ready_o(byte_ready), .byte_sop_i(byte_sop),
    .byte_eop_i(byte_eop), .ast_source_data_o(data),
    .ast_source_valid_o(valid), .ast_source_ready_i(src_ready),
    .ast_source_empty_o(empty),
    .ast_source_startofpacket_o(sop),
    .ast_source_endofpacket_o(eop), .drop_cnt_o(drop)
  );

  ast_pack #(.AST_SOURCE_ORDER(0), .DROP_CNT_W(4)) u_dut0 (
    .clk_i(clk), .srst_i(srst),
    .byte_data_i(byte_data), .byte_valid_i(byte_valid),
    .byte_ready_o(byte_ready0), .byte_sop_i(byte_sop),
    .byte_eop_i(byte_eop), .ast_source_data_o(data0),
    .ast_source_valid_o(valid0), .ast_source_ready_i(src_ready),
    .ast_source_empty_o(empty0),
    .ast_source_startofpacket_o(sop0),
    .ast_source_endofpacket_o(eop0), .drop_cnt_o(drop0)
  );

  // Packetizer model: split each framed packet into S-byte chunks.
  function automatic void model_byte(logic [7:0] b, logic s, logic e);
    beat_t x;
    if (s && !m_in_pkt) begin
      m_in_pkt = 1;
      m_sop = 1;
      m_chunk.delete();
    end else if (!m_in_pkt) begin
      m_drops++;
      return;
    end
    m_chunk.push_back(b);
    if (m_chunk.size() == S || e) begin
      x = '0;
      for (int k = 0; k < m_chunk.size(); k++) begin
        x.d1[(S-1-k)*8 +: 8] = m_chunk[k];
        x.d0[k*8 +: 8] = m_chunk[k];
      end
      x.sop = m_sop;
      x.eop = e;
      x.emp = e ? 3'(S - m_chunk.size()) : 3'd0;
      exp_q.push_back(x);
      m_chunk.delete();
      m_sop = 0;
      if (e) m_in_pkt = 0;
    end
  endfunction

  always @(negedge clk) begin
    if (srst) begin
      obs_q.delete();
      exp_q.delete();
      m_chunk.delete();
      m_in_pkt = 0;
      m_sop = 0;
      m_drops = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!valid || data !== held_d ||
          {sop, eop, empty} !== held_f)) stall_bad++;
      prev_stall = valid && !src_ready;
      held_d = data;
      held_f = {sop, eop, empty};
      if ({valid0, sop0, eop0, empty0, byte_ready0} !==
          {valid, sop, eop, empty, byte_ready}) twin_bad++;
      if (valid && src_ready) obs_q.push_back({data, data0, sop, eop, empty});
      if (byte_valid && byte_ready) model_byte(byte_data, byte_sop, byte_eop);
    end
  end

  task automatic push(input logic [7:0] d, input logic s, input logic e);
    int n;
    n = 0;
    byte_data = d;
    byte_sop = s;
    byte_eop = e;
    byte_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (byte_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        failures++;
        $display("FAIL push_timeout ready=%0b required=1", byte_ready);
        break;
      end
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [7:0] first, input int len);
    for (int i = 0; i < len; i++)
      push(first + 8'(i), i == 0, i == len - 1);
  endtask

  task automatic do_reset();
    srst = 1'b1;
    @(posedge clk);
    #1;
    srst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%0b want=0", valid);
    end
    checks++;
    if (byte_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%0b want=1", byte_ready);
    end
    checks++;
    if (drop !== 16'd0) begin
      failures++;
      $display("FAIL reset_drop got=%0d want=0", drop);
    end
    checks++;
    if ({data, sop, eop, empty} !== 69'd0) begin
      failures++;
      $display("FAIL reset_fields got=%h/%b%b/%0d want=0",
               data, sop, eop, empty);
    end
    idle(1);
  endtask

  task automatic test_full_beat();
    src_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(8'(i), i == 1, i == 8);
    @(negedge clk);
    checks++;
    if ({valid, data, sop, eop, empty} !==
        {1'b1, 64'h0102030405060708, 1'b1, 1'b1, 3'd0}) begin
      failures++;
      $display("FAIL full_beat got=%b %h %b%b %0d want=1 0102030405060708 11 0",
               valid, data, sop, eop, empty);
    end
    idle(4);
    checks++;
    if (obs_q.size() != 1) begin
      failures++;
      $display("FAIL full_beat_count got=%0d want=1", obs_q.size());
    end
  endtask

  task automatic test_partial();
    obs_q.delete();
    send_pkt(8'h01, 11);
    idle(5);
    checks++;
    if (obs_q.size() != 2) begin
      failures++;
      $display("FAIL partial_count got=%0d want=2", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== {64'h0102030405060708, 64'h0807060504030201,
                        1'b1, 1'b0, 3'd0}) begin
        failures++;
        $display("FAIL partial_beat1 got=%h want=%h", obs_q[0],
                 {64'h0102030405060708, 64'h0807060504030201, 5'b10000});
      end
      checks++;
      if (obs_q[1] !== {64'h090A0B0000000000, 64'h00000000000B0A09,
                        1'b0, 1'b1, 3'd5}) begin
        failures++;
        $display("FAIL partial_beat2 got=%h want=%h", obs_q[1],
                 {64'h090A0B0000000000, 64'h00000000000B0A09, 5'b01101});
      end
    end
  endtask

  task automatic test_backpressure();
    obs_q.delete();
    stall_bad = 0;
    src_ready = 1'b0;
    for (int i = 1; i <= 16; i++) push(8'(i), i == 1, 1'b0);
    @(negedge clk);
    checks++;
    if ({byte_ready, valid, data} !== {1'b0, 1'b1, 64'h0102030405060708}) begin
      failures++;
      $display("FAIL bp_stall got=%b %b %h want=0 1 0102030405060708",
               byte_ready, valid, data);
    end
    idle(6);
    src_ready = 1'b1;
    for (int i = 17; i <= 24; i++) push(8'(i), 1'b0, i == 24);
    idle(6);
    checks++;
    if (obs_q.size() != 3) begin
      failures++;
      $display("FAIL bp_count got=%0d want=3", obs_q.size());
    end else begin
      checks++;
      if ({obs_q[0].d1, obs_q[0].sop, obs_q[0].eop} !==
          {64'h0102030405060708, 2'b10}) begin
        failures++;
        $display("FAIL bp_beat1 got=%h want=0102030405060708", obs_q[0].d1);
      end
      checks++;
      if ({obs_q[1].d1, obs_q[1].sop, obs_q[1].eop} !==
          {64'h090A0B0C0D0E0F10, 2'b00}) begin
        failures++;
        $display("FAIL bp_beat2 got=%h want=090A0B0C0D0E0F10", obs_q[1].d1);
      end
      checks++;
      if ({obs_q[2].d1, obs_q[2].sop, obs_q[2].eop, obs_q[2].emp} !==
          {64'h1112131415161718, 2'b01, 3'd0}) begin
        failures++;
        $display("FAIL bp_beat3 got=%h want=1112131415161718", obs_q[2].d1);
      end
    end
    checks++;
    if (stall_bad != 0) begin
      failures++;
      $display("FAIL bp_stable got=%0d want=0", stall_bad);
    end
  endtask

  task automatic test_single();
    obs_q.delete();
    push(8'hAA, 1'b1, 1'b1);
    push(8'h55, 1'b1, 1'b0);
    push(8'h66, 1'b0, 1'b1);
    idle(5);
    checks++;
    if (obs_q.size() != 2) begin
      failures++;
      $display("FAIL single_count got=%0d want=2", obs_q.size());
    end else begin
      checks++;
      if ({obs_q[0].d1, obs_q[0].sop, obs_q[0].eop, obs_q[0].emp} !==
          {64'hAA00000000000000, 2'b11, 3'd7}) begin
        failures++;
        $display("FAIL single_beat got=%h %b%b %0d want=AA00000000000000 11 7",
                 obs_q[0].d1, obs_q[0].sop, obs_q[0].eop, obs_q[0].emp);
      end
      checks++;
      if ({obs_q[1].d1, obs_q[1].sop, obs_q[1].eop, obs_q[1].emp} !==
          {64'h5566000000000000, 2'b11, 3'd6}) begin
        failures++;
        $display("FAIL single_next got=%h %b%b %0d want=5566000000000000 11 6",
                 obs_q[1].d1, obs_q[1].sop, obs_q[1].eop, obs_q[1].emp);
      end
    end
  endtask

  task automatic test_drop();
    do_reset();
    for (int i = 0; i < 3; i++) push(8'hE0 + 8'(i), 1'b0, 1'b0);
    idle(3);
    checks++;
    if ({drop, drop0} !== {16'd3, 4'd3} || obs_q.size() != 0) begin
      failures++;
      $display("FAIL drop_three got=%0d/%0d beats=%0d want=3/3 beats=0",
               drop, drop0, obs_q.size());
    end
    send_pkt(8'h31, 8);
    idle(5);
    checks++;
    if (obs_q.size() != 1 ||
        obs_q[0] !== {64'h3132333435363738, 64'h3837363534333231, 5'b11000}) begin
      failures++;
      $display("FAIL drop_pkt beats=%0d want=1 with 3132333435363738",
               obs_q.size());
    end
    for (int i = 0; i < 11; i++) push(8'h70, 1'b0, 1'b0);
    idle(2);
    checks++;
    if (drop0 !== 4'd14) begin
      failures++;
      $display("FAIL drop_premax got=%0d want=14", drop0);
    end
    push(8'h71, 1'b0, 1'b1);
    push(8'h72, 1'b0, 1'b0);
    idle(2);
    checks++;
    if ({drop0, drop} !== {4'hF, 16'd16}) begin
      failures++;
      $display("FAIL drop_saturate got=%0d/%0d want=15/16", drop0, drop);
    end
  endtask

  task automatic test_reset_mid();
    send_pkt(8'h41, 5);
    do_reset();
    @(negedge clk);
    checks++;
    if ({valid, drop, byte_ready} !== {1'b0, 16'd0, 1'b1}) begin
      failures++;
      $display("FAIL midreset got=v%b d%0d r%b want=v0 d0 r1",
               valid, drop, byte_ready);
    end
    idle(1);
    push(8'h46, 1'b0, 1'b0);
    push(8'h47, 1'b0, 1'b1);
    idle(3);
    checks++;
    if (drop !== 16'd2 || obs_q.size() != 0) begin
      failures++;
      $display("FAIL midreset_drop got=%0d beats=%0d want=2 beats=0",
               drop, obs_q.size());
    end
    send_pkt(8'h21, 8);
    idle(5);
    checks++;
    if (obs_q.size() != 1 ||
        obs_q[0].d1 !== 64'h2122232425262728 || obs_q[0].sop !== 1'b1) begin
      failures++;
      $display("FAIL midreset_pkt beats=%0d want=1 with 2122232425262728",
               obs_q.size());
    end
  endtask

  task automatic test_random();
    bit done;
    do_reset();
    stall_bad = 0;
    twin_bad = 0;
    done = 0;
    fork
      begin
        for (int p = 0; p < 30; p++) begin
          int len;
          len = $urandom_range(1, 20);
          if ($urandom_range(0, 3) == 0)
            push(8'($urandom_range(0, 255)), 1'b0, 1'($urandom_range(0, 1)));
          for (int i = 0; i < len; i++)
            push(8'($urandom), i == 0 || $urandom_range(0, 9) == 0,
                 i == len - 1);
          if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          src_ready = $urandom_range(0, 3) != 0;
        end
      end
    join
    src_ready = 1'b1;
    idle(20);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rand_beat%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (drop !== 16'(m_drops) || drop0 !== 4'(m_drops > 15 ? 15 : m_drops)) begin
      failures++;
      $display("FAIL rand_drop got=%0d/%0d want=%0d", drop, drop0, m_drops);
    end
    checks++;
    if (stall_bad != 0 || twin_bad != 0) begin
      failures++;
      $display("FAIL rand_stall got=%0d/%0d want=0/0", stall_bad, twin_bad);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    srst = 1'b0;
    test_reset();
    test_full_beat();
    test_partial();
    test_backpressure();
    test_single();
    test_drop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
